wide_move_sequencer: RTL and testbench

- Multi-cycle control sequencer for the wide-immediate move family: MOVZ, MOVK, and optionally MOVN.
- Parametrised successor to the single-shift MOVZ/MOVK control-word generator. Adds:
  - hw shift field (LSL 0/16/32/48), applied per parameter;
  - an owned state register and start/busy/done handshake;
  - illegal-encoding detection.
- Sits between the main control unit and the datapath: drives the 31-bit control word and the K constant while the control unit is stalled on busy.

---
 rtl/wide_move_sequencer.sv | 119 +++++++++++
 tb/tb_wide_move_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wide_move_sequencer.sv
// Multi-cycle sequencer for MOVZ/MOVK (and MOVN when WIDE_MOVE_MOVN_EN is defined).
// Drives the datapath control word and K constant while the control unit waits on busy.
module wide_move_sequencer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned HW_MAX     = DATA_WIDTH / IMM_WIDTH - 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           instruction,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [30:0]           controlWord,
  output logic [DATA_WIDTH-1:0] K
);

  localparam logic [8:0] OP_MOVZ  = 9'h1A5;
  localparam logic [8:0] OP_MOVK  = 9'h1E5;
  localparam logic [8:0] OP_MOVN  = 9'h125;
  localparam logic [4:0] FSEL_AND = 5'b00000;
  localparam logic [4:0] FSEL_OR  = 5'b00100;
  localparam logic [4:0] XZR      = 5'd31;
  // regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL
  localparam logic [8:0] ALU_WRITE_BITS = 9'b100100100;

  typedef enum logic [1:0] {IDLE, CLEAR, MERGE, FAULT} state_t;

  state_t      state;
  logic [31:0] instr_q;

  function automatic logic is_movn(input logic [31:0] ins);
`ifdef WIDE_MOVE_MOVN_EN
    return ins[31:23] == OP_MOVN;
`else
    return 1'b0 && (ins[31:23] == OP_MOVN);
`endif
  endfunction

  // First execute state for a newly accepted instruction.
  function automatic state_t classify(input logic [31:0] ins);
    logic [8:0] op;
    op = ins[31:23];
    if (32'(ins[22:21]) > HW_MAX) return FAULT;
    if (op == OP_MOVK) return CLEAR;
    if (op == OP_MOVZ || is_movn(ins)) return MERGE;
    return FAULT;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] k_for(input state_t st, input logic [31:0] ins);
    int unsigned           sh;
    logic [DATA_WIDTH-1:0] imm_k;
    logic [DATA_WIDTH-1:0] mask;
    sh    = 32'(ins[22:21]) * IMM_WIDTH;
    imm_k = DATA_WIDTH'(ins[20:5]) << sh;
    mask  = DATA_WIDTH'({IMM_WIDTH{1'b1}}) << sh;
    case (st)
      CLEAR:   return ~mask;
      MERGE:   return is_movn(ins) ? ~imm_k : imm_k;
      default: return '0;
    endcase
  endfunction

  function automatic logic [30:0] cw_for(input state_t st, input logic [31:0] ins);
    logic [4:0] rd;
    logic [4:0] sa;
    rd = ins[4:0];
    // MOVK merges into the cleared Rd; MOVZ/MOVN start from zero.
    sa = (ins[31:23] == OP_MOVK) ? rd : XZR;
    case (st)
      CLEAR:   return {2'b00, rd, rd, 5'd0, FSEL_AND, ALU_WRITE_BITS};
      MERGE:   return {2'b01, rd, sa, 5'd0, FSEL_OR, ALU_WRITE_BITS};
      default: return '0;
    endcase
  endfunction

  // State, latched instruction and outputs for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      instr_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      controlWord <= '0;
      K           <= '0;
    end else begin
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      controlWord <= '0;
      K           <= '0;
      case (state)
        IDLE: begin
          state <= IDLE;
          if (start) begin
            state       <= classify(instruction);
            instr_q     <= instruction;
            busy        <= 1'b1;
            done        <= classify(instruction) != CLEAR;
            illegal     <= classify(instruction) == FAULT;
            controlWord <= cw_for(classify(instruction), instruction);
            K           <= k_for(classify(instruction), instruction);
          end
        end
        CLEAR: begin
          state       <= MERGE;
          busy        <= 1'b1;
          done        <= 1'b1;
          controlWord <= cw_for(MERGE, instr_q);
          K           <= k_for(MERGE, instr_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_move_sequencer.sv
// Self-checking bench for wide_move_sequencer: directed cases plus randomized
// instruction streams checked against a per-instruction cycle model.
module tb_wide_move_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic        busy, done, illegal;
  logic [30:0] cw;
  logic [63:0] k;

  logic        start32;
  logic [31:0] instr32;
  logic        busy32, done32, ill32;
  logic [30:0] cw32;
  logic [31:0] k32;

  int total = 0;
  int bad   = 0;

  // Model output for the current instruction (up to two execute cycles).
  int          m_n;
  logic [30:0] m_cw   [2];
  logic [63:0] m_k    [2];
  logic        m_done [2];
  logic        m_ill  [2];
  logic [30:0] o_cw   [2];
  logic [63:0] o_k    [2];
  logic        o_done [2];

  wide_move_sequencer u_dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .busy(busy), .done(done), .illegal(illegal), .controlWord(cw), .K(k)
  );

  wide_move_sequencer #(.DATA_WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(start32), .instruction(instr32),
    .busy(busy32), .done(done32), .illegal(ill32), .controlWord(cw32), .K(k32)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [8:0] op, input logic [1:0] hw,
                                     input logic [15:0] imm, input logic [4:0] rd);
    return {op, hw, imm, rd};
  endfunction

  // Control word for an ALU write: Psel, DA, SA, SB=0, Fsel, regW/EN_ALU/Bsel set.
  function automatic logic [30:0] alu_cw(input logic [1:0] psel, input logic [4:0] da,
                                         input logic [4:0] sa, input logic [4:0] fsel);
    return {psel, da, sa, 5'd0, fsel, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  // Behaviour of one instruction on the 64-bit datapath, written as a cycle list.
  task automatic model(input logic [31:0] ins);
    logic [8:0]  op;
    logic [63:0] imm_sh;
    logic [63:0] field;
    logic        movn_ok;
    op      = ins[31:23];
    imm_sh  = 64'(ins[20:5]) << (16 * int'(ins[22:21]));
    field   = 64'h000000000000FFFF << (16 * int'(ins[22:21]));
`ifdef WIDE_MOVE_MOVN_EN
    movn_ok = 1'b1;
`else
    movn_ok = 1'b0;
`endif
    if (op == 9'h1E5) begin
      m_n = 2;
      m_cw[0] = alu_cw(2'b00, ins[4:0], ins[4:0], 5'b00000);
      m_k[0]  = ~field;
      m_done[0] = 1'b0; m_ill[0] = 1'b0;
      m_cw[1] = alu_cw(2'b01, ins[4:0], ins[4:0], 5'b00100);
      m_k[1]  = imm_sh;
      m_done[1] = 1'b1; m_ill[1] = 1'b0;
    end else if (op == 9'h1A5 || (op == 9'h125 && movn_ok)) begin
      m_n = 1;
      m_cw[0] = alu_cw(2'b01, ins[4:0], 5'd31, 5'b00100);
      m_k[0]  = (op == 9'h125) ? ~imm_sh : imm_sh;
      m_done[0] = 1'b1; m_ill[0] = 1'b0;
    end else begin
      m_n = 1;
      m_cw[0] = '0; m_k[0] = '0;
      m_done[0] = 1'b1; m_ill[0] = 1'b1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ill"},  64'(illegal), 64'd0);
    chk({tag, "_cw"},   64'(cw), 64'd0);
    chk({tag, "_k"},    k, 64'd0);
  endtask

  // Issue one instruction from IDLE and follow it to the IDLE cycle after done.
  task automatic run_txn(input string tag, input logic [31:0] ins, input logic glitch);
    model(ins);
    start = 1'b1;
    instruction = ins;
    @(posedge clock); #1;
    for (int c = 0; c < m_n; c++) begin
      start = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
      instruction = $urandom;
      o_cw[c] = cw; o_k[c] = k; o_done[c] = done;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_done"}, 64'(done), 64'(m_done[c]));
      chk({tag, "_ill"},  64'(illegal), 64'(m_ill[c]));
      chk({tag, "_cw"},   64'(cw), 64'(m_cw[c]));
      chk({tag, "_k"},    k, m_k[c]);
      @(posedge clock); #1;
    end
    start = 1'b0;
    chk_idle({tag, "_after"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instruction = '0;
    start32 = 1'b0; instr32 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk_idle("idle");
    end

    // MOVZ X3,#0xBEEF,LSL16
    run_txn("movz", 32'hD2B7DDE3, 1'b0);
    chk("movz_k_const", o_k[0], 64'h00000000BEEF0000);
    chk("movz_da", 64'(o_cw[0][28:24]), 64'd3);
    chk("movz_sa", 64'(o_cw[0][23:19]), 64'd31);
    chk("movz_fsel", 64'(o_cw[0][13:9]), 64'b00100);
    chk("movz_psel", 64'(o_cw[0][30:29]), 64'b01);
    chk("movz_regw", 64'(o_cw[0][8]), 64'd1);

    // MOVK X5,#0x1234,LSL48
    run_txn("movk", 32'hF2E24685, 1'b0);
    chk("movk_k0_const", o_k[0], 64'h0000FFFFFFFFFFFF);
    chk("movk_fsel0", 64'(o_cw[0][13:9]), 64'b00000);
    chk("movk_psel0", 64'(o_cw[0][30:29]), 64'b00);
    chk("movk_sa0", 64'(o_cw[0][23:19]), 64'd5);
    chk("movk_da0", 64'(o_cw[0][28:24]), 64'd5);
    chk("movk_done0", 64'(o_done[0]), 64'd0);
    chk("movk_k1_const", o_k[1], 64'h1234000000000000);
    chk("movk_fsel1", 64'(o_cw[1][13:9]), 64'b00100);
    chk("movk_psel1", 64'(o_cw[1][30:29]), 64'b01);

    // start pulsed throughout the MOVK sequence is ignored
    run_txn("movk_busystart", 32'hF2E24685, 1'b1);
    chk("movk_busystart_k1", o_k[1], 64'h1234000000000000);

    // reset during CLEAR aborts without a MERGE write
    start = 1'b1; instruction = 32'hF2E24685;
    @(posedge clock); #1;
    start = 1'b0;
    chk("abort_clear_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk_idle("abort_rst");
    @(posedge clock); #1;
    chk_idle("abort_next");
    chk("abort_regw", 64'(cw[8]), 64'd0);

    // 9'h025 unknown op; 9'h125 MOVN depends on the build
    run_txn("op025", 32'h12800000, 1'b0);
    chk("op025_cw", 64'(o_cw[0]), 64'd0);
    run_txn("movn", 32'h92800000, 1'b0);
    run_txn("rd31", mk(9'h1A5, 2'd3, 16'hA5A5, 5'd31), 1'b0);

    // 32-bit datapath: hw=2 is out of range, hw=1 is legal
    start32 = 1'b1; instr32 = 32'hD2C00000;
    @(posedge clock); #1;
    start32 = 1'b0;
    chk("w32_hw2_ill", 64'(ill32), 64'd1);
    chk("w32_hw2_done", 64'(done32), 64'd1);
    chk("w32_hw2_cw", 64'(cw32), 64'd0);
    @(posedge clock); #1;
    chk("w32_hw2_idle", 64'(busy32), 64'd0);
    start32 = 1'b1; instr32 = mk(9'h1A5, 2'd1, 16'hABCD, 5'd1);
    @(posedge clock); #1;
    start32 = 1'b0;
    chk("w32_hw1_ill", 64'(ill32), 64'd0);
    chk("w32_hw1_k", 64'(k32), 64'h00000000ABCD0000);
    chk("w32_hw1_cw", 64'(cw32), 64'(alu_cw(2'b01, 5'd1, 5'd31, 5'b00100)));
    @(posedge clock); #1;

    // randomized stream with busy-time start noise and idle gaps
    for (int t = 0; t < 80; t++) begin
      logic [8:0]  op;
      logic [31:0] ins;
      case ($urandom_range(0, 3))
        0:       op = 9'h1A5;
        1:       op = 9'h1E5;
        2:       op = 9'h125;
        default: op = 9'($urandom);
      endcase
      ins = mk(op, 2'($urandom), 16'($urandom), 5'($urandom));
      run_txn("rand", ins, 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clock); #1;
        chk_idle("gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
